event_indicator: RTL and testbench

Output-side companion to the key debouncer: where the debouncer turns a noisy physical input into a one-cycle internal pulse, this block turns one-cycle internal event pulses into human-visible LED blinks. Each event produces exactly one blink of fixed on/off length. Events arriving during a blink are queued in a saturating pending counter, so back-to-back pulses (e.g. repeated `o_neg` from the debouncer or "start" strobes to the random generator) remain countable on LEDG/LEDR at the board top.

---
 rtl/event_indicator_pkg.sv | 15 +
 rtl/event_indicator.sv | 111 +++++++++++
 tb/tb_event_indicator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/event_indicator_pkg.sv
// Shared types for the event indicator: blink FSM states and a small
// compile-time helper used to size the phase counter.
package event_indicator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/event_indicator.sv
// Turns one-cycle event strobes into fixed-length LED blinks, queueing
// events that arrive mid-blink in a saturating pending counter.
module event_indicator
  import event_indicator_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 12_500_000,
  parameter int unsigned GAP_CYCLES = 12_500_000,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_event,
  input  logic              i_clear,
  output logic              o_led,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  localparam int unsigned CNT_W = $clog2(max_u(ON_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t             state_q, state_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic [PEND_W-1:0]  pend_base, pend_nx;
  logic               ovf_nx, led_nx, busy_nx;
  logic               gap_exit;

  // A clear takes effect before the event in the same cycle is accounted for.
  assign pend_base = i_clear ? '0 : o_pending;
  assign gap_exit  = (state_q == GAP) && (cnt_q == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      o_pending  <= '0;
      o_overflow <= 1'b0;
      o_led      <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      o_pending  <= pend_nx;
      o_overflow <= ovf_nx;
      o_led      <= led_nx;
      o_busy     <= busy_nx;
    end
  end

  // Phase sequencing; one down-counter times both ON and GAP.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_event) begin
          state_nx = ON;
          cnt_nx   = ON_LOAD;
        end
      end
      ON: begin
        if (cnt_q == '0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LOAD;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if ((pend_base != '0) || i_event) begin
            state_nx = ON;
            cnt_nx   = ON_LOAD;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Pending bookkeeping and next values of the registered outputs.
  always_comb begin
    pend_nx = pend_base;
    ovf_nx  = i_clear ? 1'b0 : o_overflow;
    led_nx  = (state_nx == ON);
    busy_nx = (state_nx != IDLE);
    if (gap_exit) begin
      // A coincident event replaces the dequeued one, so only a bare exit drains.
      if ((pend_base != '0) && !i_event) begin
        pend_nx = pend_base - PEND_W'(1);
      end
    end else if ((state_q != IDLE) && i_event) begin
      if (pend_base == PEND_MAX) begin
        ovf_nx = 1'b1;
      end else begin
        pend_nx = pend_base + PEND_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_event_indicator.sv
// Scoreboard bench for event_indicator: a time-based blink model predicts
// every cycle's outputs; a monitor compares them after each clock edge.
module tb_event_indicator;

  localparam int ON     = 3;
  localparam int GAP    = 2;
  localparam int PW     = 2;
  localparam int PERIOD = ON + GAP;
  localparam int PMAX   = (1 << PW) - 1;

  typedef struct {
    bit led;
    bit busy;
    int pend;
    bit ovf;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ev  = 1'b0;
  logic          clr = 1'b0;
  logic          led, busy, ovf;
  logic [PW-1:0] pend;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  // Reference model: blink timing is expressed as the start cycle of the
  // current blink; pending/overflow are plain integers.
  int t      = 0;
  int start  = -1000;
  int pend_m = 0;
  bit ovf_m  = 1'b0;

  event_indicator #(
    .ON_CYCLES (ON),
    .GAP_CYCLES(GAP),
    .PEND_W    (PW)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_event   (ev),
    .i_clear   (clr),
    .o_led     (led),
    .o_busy    (busy),
    .o_pending (pend),
    .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  function automatic bit in_blink(input int tt);
    return (tt >= start) && ((tt - start) < PERIOD);
  endfunction

  task automatic check(input string name, input int act, input int expv, input int cyc);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic model_step(input bit e, input bit c);
    bit busy_now, last;
    exp_t x;
    if (c) begin
      pend_m = 0;
      ovf_m  = 1'b0;
    end
    busy_now = in_blink(t);
    last     = busy_now && ((t - start) == PERIOD - 1);
    if (!busy_now) begin
      if (e) start = t + 1;
    end else if (last) begin
      if (pend_m > 0 || e) begin
        start = t + 1;
        if (pend_m > 0 && !e) pend_m--;
      end
    end else if (e) begin
      if (pend_m == PMAX) ovf_m = 1'b1;
      else pend_m++;
    end
    t++;
    x.busy = in_blink(t);
    x.led  = x.busy && ((t - start) < ON);
    x.pend = pend_m;
    x.ovf  = ovf_m;
    x.cyc  = t;
    q.push_back(x);
  endtask

  task automatic drive(input bit e, input bit c);
    @(negedge clk);
    ev  = e;
    clr = c;
    model_step(e, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  // Async reset pulse between edges; outputs must drop without a clock.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_led",  int'(led),  0, t);
    check("rst_busy", int'(busy), 0, t);
    check("rst_pend", int'(pend), 0, t);
    check("rst_ovf",  int'(ovf),  0, t);
    rst    = 1'b0;
    start  = -1000;
    pend_m = 0;
    ovf_m  = 1'b0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("led",  int'(led),  int'(x.led),  x.cyc);
        check("busy", int'(busy), int'(x.busy), x.cyc);
        check("pend", int'(pend), x.pend,       x.cyc);
        check("ovf",  int'(ovf),  int'(x.ovf),  x.cyc);
      end
    end
  end

  initial begin : stimulus
    #1;
    check("init_led",  int'(led),  0, 0);
    check("init_busy", int'(busy), 0, 0);
    check("init_pend", int'(pend), 0, 0);
    check("init_ovf",  int'(ovf),  0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single blink
    idle(10); drive(1, 0); idle(14);
    // Four back-to-back events queue three blinks
    for (int i = 0; i < 4; i++) drive(1, 0);
    idle(25);
    // Six events saturate pending and set overflow
    for (int i = 0; i < 6; i++) drive(1, 0);
    idle(30);
    // Event in the last GAP cycle chains straight into a new blink
    drive(1, 0); idle(4); drive(1, 0); idle(10);
    // Clear drops pending and overflow without aborting the blink
    for (int i = 0; i < 3; i++) drive(1, 0);
    drive(0, 1); idle(10);
    // Clear with coincident event mid-blink leaves one pending
    drive(1, 0); drive(1, 0); drive(1, 1); idle(15);
    // Reset mid-blink, then a fresh blink
    drive(1, 0); drive(1, 0); pulse_reset(); idle(6); drive(1, 0); idle(10);

    // Randomized traffic with varying event density and rare resets
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      dens = $urandom_range(5, 80);
      for (int i = 0; i < 200; i++) begin
        drive(($urandom_range(0, 99) < dens), ($urandom_range(0, 99) < 3));
        if ($urandom_range(0, 149) == 0) pulse_reset();
      end
    end
    idle(20);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0, t);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
